// File: rtl/io_blocks_pkg.sv
// io_blocks_pkg: shared widths, scan FSM state encoding and the tap-quality
// test used by the link delay scanner.
//   DELAY_W  IDELAY tap width
//   ERR_W    bit-align error counter width
//   EYE_W    eye width / run length width (scan points)
package io_blocks_pkg;

    localparam int unsigned DELAY_W = 9;
    localparam int unsigned ERR_W   = 16;
    localparam int unsigned EYE_W   = 10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL,
        S_SET,
        S_WAIT_RDY,
        S_CLR,
        S_DWELL,
        S_SAMPLE,
        S_CENTER,
        S_CENTER_WAIT,
        S_FIN
    } scan_state_t;

    // A saturated counter never counts as good, even with a wide-open threshold.
    function automatic logic is_good_tap(input logic [ERR_W-1:0] err,
                                         input logic [ERR_W-1:0] thr);
        return (err <= thr) && (err != {ERR_W{1'b1}});
    endfunction

endpackage

// File: rtl/link_delay_scanner_if.sv
// link_delay_scanner_if: delay-control bus between the scanner and the
// differential input block.
//   delay_set         one-hot load strobe per link
//   delay_in          tap value shared by all links
//   reset_counters    one-hot error-counter clear per link
//   delay_ready       per-link delay-settled flag
//   bit_align_errors  per-link error counters, link i at [ERR_W*i +: ERR_W]
// master = scanner side, slave = input-block side.
interface link_delay_scanner_if
    import io_blocks_pkg::*;
#(
    parameter int unsigned NLINKS = 12
);
    logic [NLINKS-1:0]       delay_set;
    logic [DELAY_W-1:0]      delay_in;
    logic [NLINKS-1:0]       reset_counters;
    logic [NLINKS-1:0]       delay_ready;
    logic [NLINKS*ERR_W-1:0] bit_align_errors;

    modport master (
        output delay_set,
        output delay_in,
        output reset_counters,
        input  delay_ready,
        input  bit_align_errors
    );

    modport slave (
        input  delay_set,
        input  delay_in,
        input  reset_counters,
        output delay_ready,
        output bit_align_errors
    );
endinterface

// File: rtl/eye_window_tracker.sv
// eye_window_tracker: follows the current run of good scan points and keeps
// the longest run seen so far (earliest wins on a tie).
//   clk160, rst       clock, synchronous active-high reset
//   clear_i           forget run and best (start of a new link)
//   sample_valid_i    one scan point is being judged this cycle
//   good_i, last_i    verdict for the point, and whether it is the final tap
//   tap_i             tap value of the point
//   best_start_o      first tap of the best window
//   best_len_o        best window length in scan points
module eye_window_tracker
    import io_blocks_pkg::*;
(
    input  logic               clk160,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               sample_valid_i,
    input  logic               good_i,
    input  logic               last_i,
    input  logic [DELAY_W-1:0] tap_i,
    output logic [DELAY_W-1:0] best_start_o,
    output logic [EYE_W-1:0]   best_len_o
);

    logic [DELAY_W-1:0] run_start_q, run_start_d;
    logic [EYE_W-1:0]   run_len_q,   run_len_d;
    logic [DELAY_W-1:0] best_start_q, best_start_d;
    logic [EYE_W-1:0]   best_len_q,   best_len_d;
    logic [DELAY_W-1:0] cand_start;
    logic [EYE_W-1:0]   cand_len;

    // Candidate is the run as it stands after this point; it is offered to
    // best when the run ends (bad point) or the sweep ends (last point).
    always_comb begin
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        cand_start   = run_start_q;
        cand_len     = run_len_q;
        if (clear_i) begin
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (sample_valid_i) begin
            if (good_i) begin
                cand_len    = run_len_q + EYE_W'(1);
                cand_start  = (run_len_q == '0) ? tap_i : run_start_q;
                run_len_d   = cand_len;
                run_start_d = cand_start;
            end else begin
                run_len_d = '0;
            end
            if ((!good_i || last_i) && (cand_len > best_len_q)) begin
                best_start_d = cand_start;
                best_len_d   = cand_len;
            end
        end
    end

    always_ff @(posedge clk160) begin
        if (rst) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/link_delay_scanner.sv
// link_delay_scanner: per-link input-delay calibration sequencer. Sweeps each
// masked link's tap range, judges every scan point from the link's error
// counter, then programs the centre of the widest error-free window.
//   clk160, rst        clock, synchronous active-high reset
//   start, link_mask   start pulse and links to scan (latched on accept)
//   err_threshold      largest error count still judged good
//   dwell_cycles       accumulation time per tap (0 behaves as 1)
//   busy, done         scan in progress / one-cycle completion pulse
//   link_ok            window found and centred
//   link_timeout       delay_ready never came back
//   delay_result       centre tap per link, DELAY_W bits each
//   eye_width          window width per link in scan points, EYE_W bits each
//   lnk                delay-control bus (master side)
// Optional SCAN_HISTOGRAM_EN adds a 64x16 error histogram of the most recently
// scanned link, read through hist_raddr/hist_rdata (1-cycle latency), with
// hist_link naming the link it belongs to.
module link_delay_scanner
    import io_blocks_pkg::*;
#(
    parameter int unsigned NLINKS      = 12,
    parameter int unsigned TAP_STEP    = 8,
    parameter int unsigned MAX_TAP     = 511,
    parameter int unsigned RDY_TIMEOUT = 4096
) (
    input  logic                      clk160,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NLINKS-1:0]         link_mask,
    input  logic [ERR_W-1:0]          err_threshold,
    input  logic [15:0]               dwell_cycles,
    output logic                      busy,
    output logic                      done,
    output logic [NLINKS-1:0]         link_ok,
    output logic [NLINKS-1:0]         link_timeout,
    output logic [NLINKS*DELAY_W-1:0] delay_result,
    output logic [NLINKS*EYE_W-1:0]   eye_width,
`ifdef SCAN_HISTOGRAM_EN
    input  logic [5:0]                hist_raddr,
    output logic [15:0]               hist_rdata,
    output logic [3:0]                hist_link,
`endif
    link_delay_scanner_if.master      lnk
);

    localparam int unsigned LINK_W = (NLINKS > 1) ? $clog2(NLINKS) : 1;
    localparam int unsigned TMO_W  = $clog2(RDY_TIMEOUT + 1);

    scan_state_t               state_q;
    logic [NLINKS-1:0]         pend_q;
    logic [LINK_W-1:0]         cur_q;
    logic [DELAY_W-1:0]        tap_q;
    logic [TMO_W-1:0]          rdy_cnt_q;
    logic [15:0]               dwell_cnt_q;
    logic                      busy_q;
    logic                      done_q;
    logic [NLINKS-1:0]         delay_set_q;
    logic [DELAY_W-1:0]        delay_in_q;
    logic [NLINKS-1:0]         reset_counters_q;
    logic [NLINKS-1:0]         link_ok_q;
    logic [NLINKS-1:0]         link_timeout_q;
    logic [NLINKS*DELAY_W-1:0] delay_result_q;
    logic [NLINKS*EYE_W-1:0]   eye_width_q;

    logic                      found;
    logic [LINK_W-1:0]         found_idx;
    logic [NLINKS-1:0]         onehot;
    logic [ERR_W-1:0]          err_cur;
    logic                      tap_good;
    logic [DELAY_W:0]          tap_nxt;
    logic                      tap_last;
    logic [15:0]               dwell_eff;
    logic [DELAY_W-1:0]        best_start;
    logic [EYE_W-1:0]          best_len;
    logic [DELAY_W-1:0]        centre;

    // Lowest pending link.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int l = int'(NLINKS) - 1; l >= 0; l--) begin
            if (pend_q[l]) begin
                found     = 1'b1;
                found_idx = LINK_W'(l);
            end
        end
    end

    always_comb begin
        onehot        = '0;
        onehot[cur_q] = 1'b1;
    end

    assign err_cur   = lnk.bit_align_errors[32'(cur_q) * ERR_W +: ERR_W];
    assign tap_good  = is_good_tap(err_cur, err_threshold);
    // One bit wider than a tap so the sweep stops instead of wrapping to 0.
    assign tap_nxt   = (DELAY_W+1)'(tap_q) + (DELAY_W+1)'(TAP_STEP);
    assign tap_last  = tap_nxt > (DELAY_W+1)'(MAX_TAP);
    assign dwell_eff = (dwell_cycles == 16'd0) ? 16'd1 : dwell_cycles;

    // Centre of the best window, evaluated in 12 bits then cut to a tap.
    assign centre = (best_len == '0) ? '0 :
                    DELAY_W'(12'(best_start) +
                             (((12'(best_len) - 12'd1) * 12'(TAP_STEP)) >> 1));

    eye_window_tracker u_tracker (
        .clk160         (clk160),
        .rst            (rst),
        .clear_i        (state_q == S_SEL),
        .sample_valid_i (state_q == S_SAMPLE),
        .good_i         (tap_good),
        .last_i         (tap_last),
        .tap_i          (tap_q),
        .best_start_o   (best_start),
        .best_len_o     (best_len)
    );

    // Scan sequencer; strobes default low every cycle so each is a 1-cycle pulse.
    always_ff @(posedge clk160) begin
        if (rst) begin
            state_q          <= S_IDLE;
            pend_q           <= '0;
            cur_q            <= '0;
            tap_q            <= '0;
            rdy_cnt_q        <= '0;
            dwell_cnt_q      <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            delay_set_q      <= '0;
            delay_in_q       <= '0;
            reset_counters_q <= '0;
            link_ok_q        <= '0;
            link_timeout_q   <= '0;
            delay_result_q   <= '0;
            eye_width_q      <= '0;
        end else begin
            delay_set_q      <= '0;
            reset_counters_q <= '0;
            done_q           <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pend_q  <= link_mask;
                        busy_q  <= 1'b1;
                        state_q <= S_SEL;
                        for (int unsigned l = 0; l < NLINKS; l++) begin
                            if (link_mask[l]) begin
                                link_ok_q[l]                         <= 1'b0;
                                link_timeout_q[l]                    <= 1'b0;
                                delay_result_q[l*DELAY_W +: DELAY_W] <= '0;
                                eye_width_q[l*EYE_W +: EYE_W]        <= '0;
                            end
                        end
                    end
                end
                S_SEL: begin
                    if (found) begin
                        cur_q             <= found_idx;
                        pend_q[found_idx] <= 1'b0;
                        tap_q             <= '0;
                        state_q           <= S_SET;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end
                end
                S_SET: begin
                    delay_in_q  <= tap_q;
                    delay_set_q <= onehot;
                    rdy_cnt_q   <= '0;
                    state_q     <= S_WAIT_RDY;
                end
                // The first wait cycle is the load cycle itself; a stale ready
                // from the previous tap must not be taken there.
                S_WAIT_RDY, S_CENTER_WAIT: begin
                    if ((rdy_cnt_q != '0) && lnk.delay_ready[cur_q]) begin
                        state_q <= (state_q == S_WAIT_RDY) ? S_CLR : S_SEL;
                    end else if (rdy_cnt_q == TMO_W'(RDY_TIMEOUT - 1)) begin
                        link_timeout_q[cur_q] <= 1'b1;
                        link_ok_q[cur_q]      <= 1'b0;
                        state_q               <= S_SEL;
                    end else begin
                        rdy_cnt_q <= rdy_cnt_q + 1'b1;
                    end
                end
                S_CLR: begin
                    reset_counters_q <= onehot;
                    dwell_cnt_q      <= dwell_eff - 16'd1;
                    state_q          <= S_DWELL;
                end
                S_DWELL: begin
                    if (dwell_cnt_q == 16'd0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q - 16'd1;
                    end
                end
                S_SAMPLE: begin
                    if (tap_last) begin
                        state_q <= S_CENTER;
                    end else begin
                        tap_q   <= DELAY_W'(tap_nxt);
                        state_q <= S_SET;
                    end
                end
                S_CENTER: begin
                    delay_in_q                               <= centre;
                    delay_set_q                              <= onehot;
                    link_ok_q[cur_q]                         <= (best_len != '0);
                    delay_result_q[cur_q*DELAY_W +: DELAY_W] <= centre;
                    eye_width_q[cur_q*EYE_W +: EYE_W]        <= best_len;
                    rdy_cnt_q                                <= '0;
                    state_q                                  <= S_CENTER_WAIT;
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign link_ok            = link_ok_q;
    assign link_timeout       = link_timeout_q;
    assign delay_result       = delay_result_q;
    assign eye_width          = eye_width_q;
    assign lnk.delay_set      = delay_set_q;
    assign lnk.delay_in       = delay_in_q;
    assign lnk.reset_counters = reset_counters_q;

`ifdef SCAN_HISTOGRAM_EN
    logic [15:0] hist_mem [64];
    logic [15:0] hist_rdata_q;

    // Indexed by scan point; contents are not cleared by reset.
    always_ff @(posedge clk160) begin
        if (state_q == S_SAMPLE) begin
            hist_mem[6'(32'(tap_q) / TAP_STEP)] <= err_cur;
        end
        hist_rdata_q <= hist_mem[hist_raddr];
    end

    assign hist_rdata = hist_rdata_q;
    assign hist_link  = 4'(cur_q);
`endif

endmodule
